// File: rtl/ms_es_clkdiv_nmul.sv
// ms_es_clkdiv_nmul -- exact deterministic stochastic-computing multiplier.
//   Each operand x_i becomes the unary stream (cnt_i < x_i), where cnt_i is the
//   i-th DATA_WIDTH-bit digit (digit 0 = LSBs) of one master counter. The ANDed
//   streams are counted; after 2^(DATA_WIDTH*NUM_INPUTS) enabled RUN cycles the
//   accumulator holds the exact product x_0 * x_1 * ... * x_{N-1}.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset (aborts any run, clears result)
//   en           start request in IDLE, advance enable (stall when low) in RUN
//   bin_data_in  unpacked operand array, sampled only on the start edge
//   bin_data_out product, zero-extended to WXIP1, held until the next done
//   done         one-cycle completion pulse, coincident with the new result
// Optional feature macro: MS_ES_EARLY_TERM_EN -- a start with any zero operand
//   skips the RUN phase and completes with product 0 one cycle after start.
module ms_es_clkdiv_nmul #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int WXIP1      = DATA_WIDTH * NUM_INPUTS + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS],
  output logic [WXIP1-1:0]      bin_data_out,
  output logic                  done
);

  localparam int W = DATA_WIDTH * NUM_INPUTS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [W-1:0]          cnt_q, cnt_d;
  logic [W-1:0]          acc_q, acc_d;
  logic [W-1:0]          res_q, res_d;
  logic [DATA_WIDTH-1:0] opr_q [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] opr_d [NUM_INPUTS];
  logic                  done_q, done_d;
  logic                  stream_bit;

  // AND of all unary streams for the current master-counter value.
  always_comb begin
    stream_bit = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (cnt_q[i*DATA_WIDTH +: DATA_WIDTH] >= opr_q[i]) begin
        stream_bit = 1'b0;
      end
    end
  end

`ifdef MS_ES_EARLY_TERM_EN
  logic any_zero;

  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (bin_data_in[i] == '0) begin
        any_zero = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opr_d   = opr_q;
    res_d   = res_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          opr_d   = bin_data_in;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
`ifdef MS_ES_EARLY_TERM_EN
          // Product is known to be zero; accumulator is already cleared.
          if (any_zero) begin
            state_d = S_DONE;
          end
`endif
        end
      end

      S_RUN: begin
        if (en) begin
          acc_d = acc_q + W'(stream_bit);
          // Wrap to zero on the final cycle is harmless: the counter is
          // always cleared again on the next start.
          cnt_d = cnt_q + W'(1);
          if (&cnt_q) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // Result and pulse are registered together, so done and the new
        // bin_data_out become visible in the same cycle (back in IDLE).
        res_d   = acc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        opr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      done_q  <= done_d;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        opr_q[i] <= opr_d[i];
      end
    end
  end

  assign bin_data_out = WXIP1'(res_q);
  assign done         = done_q;

endmodule

// File: tb/tb_ms_es_clkdiv_nmul.sv
// Testbench for ms_es_clkdiv_nmul: a 3x2 instance (A) and a 2x3 instance (B).
// Expected products come from plain multiplication; expected latency is
// 2^(DW*N)+1 edges from the start edge plus one edge per stalled RUN cycle.
module tb_ms_es_clkdiv_nmul;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b;
  logic [2:0] xa [2];
  logic [1:0] xb [3];
  logic [6:0] out_a, out_b;
  logic       done_a, done_b;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  ms_es_clkdiv_nmul #(.DATA_WIDTH(3), .NUM_INPUTS(2), .WXIP1(7)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .bin_data_in(xa),
    .bin_data_out(out_a), .done(done_a)
  );

  ms_es_clkdiv_nmul #(.DATA_WIDTH(2), .NUM_INPUTS(3), .WXIP1(7)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .bin_data_in(xb),
    .bin_data_out(out_b), .done(done_b)
  );

  typedef struct {
    int x0;
    int x1;
    int stall_at;
    int stall_len;
    int prod;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int exp_lat(input bit has_zero, input int slen);
`ifdef MS_ES_EARLY_TERM_EN
    if (has_zero) return 1;
`endif
    return 65 + slen;
  endfunction

  // One operation on A. lat = edges from start edge to first visible done
  // (-1 on timeout). Inputs are scrambled after the start edge.
  task automatic run_a(input int x0, input int x1, input int sat, input int slen,
                       output int lat, output int res);
    @(negedge clk);
    xa[0] = 3'(x0); xa[1] = 3'(x1); en_a = 1'b1;
    @(posedge clk);
    lat = -1; res = 0;
    for (int e = 1; e <= 400; e++) begin
      @(negedge clk);
      if (done_a) begin
        lat = e - 1; res = int'(out_a);
        break;
      end
      en_a  = !(e >= sat && e < sat + slen);
      xa[0] = 3'($urandom); xa[1] = 3'($urandom);
      @(posedge clk);
    end
    en_a = 1'b0;
  endtask

  task automatic run_b(input int x0, input int x1, input int x2,
                       output int lat, output int res);
    @(negedge clk);
    xb[0] = 2'(x0); xb[1] = 2'(x1); xb[2] = 2'(x2); en_b = 1'b1;
    @(posedge clk);
    lat = -1; res = 0;
    for (int e = 1; e <= 400; e++) begin
      @(negedge clk);
      if (done_b) begin
        lat = e - 1; res = int'(out_b);
        break;
      end
      xb[0] = 2'($urandom); xb[1] = 2'($urandom); xb[2] = 2'($urandom);
      @(posedge clk);
    end
    en_b = 1'b0;
  endtask

  // Done must be a single-cycle pulse and the result must be held afterwards.
  task automatic post_a(input string tag, input int res_exp);
    @(negedge clk);
    chk({tag, " done_low_after"}, done_a, 0);
    chk({tag, " out_held"}, out_a, res_exp);
  endtask

  initial begin
    vec_t tbl[8];
    int lat, res, x0, x1, x2, sat, slen, first, second, bad, ndone;

    tbl[0] = '{5, 7, 0, 0, 35};
    tbl[1] = '{0, 5, 0, 0, 0};
    tbl[2] = '{7, 7, 0, 0, 49};
    tbl[3] = '{6, 3, 20, 10, 18};
    tbl[4] = '{1, 1, 0, 0, 1};
    tbl[5] = '{7, 0, 0, 0, 0};
    tbl[6] = '{3, 4, 64, 2, 12};
    tbl[7] = '{2, 2, 1, 3, 4};

    en_a = 1'b0; en_b = 1'b0;
    xa[0] = '0; xa[1] = '0;
    xb[0] = '0; xb[1] = '0; xb[2] = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset out_a", out_a, 0);
    chk("reset done_a", done_a, 0);
    chk("reset out_b", out_b, 0);
    chk("reset done_b", done_b, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors on A.
    foreach (tbl[i]) begin
      run_a(tbl[i].x0, tbl[i].x1, tbl[i].stall_at, tbl[i].stall_len, lat, res);
      chk($sformatf("tbl%0d latency", i), lat,
          exp_lat(tbl[i].x0 == 0 || tbl[i].x1 == 0, tbl[i].stall_len));
      chk($sformatf("tbl%0d product", i), res, tbl[i].prod);
      post_a($sformatf("tbl%0d", i), tbl[i].prod);
    end

    // Randomized vectors on A with random stall windows inside RUN.
    for (int k = 0; k < 12; k++) begin
      x0   = int'($urandom_range(0, 7));
      x1   = int'($urandom_range(0, 7));
      slen = int'($urandom_range(0, 4));
      sat  = int'($urandom_range(1, 64));
      run_a(x0, x1, sat, slen, lat, res);
      chk($sformatf("rndA%0d latency", k), lat, exp_lat(x0 == 0 || x1 == 0, slen));
      chk($sformatf("rndA%0d product", k), res, x0 * x1);
    end

    // Back-to-back with en held high: two pulses 66 cycles apart, result held.
    @(negedge clk);
    xa[0] = 3'd7; xa[1] = 3'd7; en_a = 1'b1;
    @(posedge clk);
    first = -1; second = -1; bad = 0;
    for (int e = 1; e <= 300; e++) begin
      @(negedge clk);
      if (done_a) begin
        if (first < 0) first = e - 1;
        else second = e - 1;
        chk("b2b pulse value", out_a, 49);
      end else if (first >= 0 && out_a != 7'd49) begin
        bad++;
      end
      if (second >= 0) break;
      @(posedge clk);
    end
    en_a = 1'b0;
    chk("b2b first latency", first, 65);
    chk("b2b spacing", second - first, 66);
    chk("b2b hold cycles bad", bad, 0);

    // Reset in mid-run: immediate clear, and the aborted run never completes.
    @(negedge clk);
    xa[0] = 3'd4; xa[1] = 3'd4; en_a = 1'b1;
    @(posedge clk);
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst out_a", out_a, 0);
    chk("midrst done_a", done_a, 0);
    @(negedge clk);
    rst  = 1'b1;
    en_a = 1'b0;
    ndone = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    chk("midrst no done", ndone, 0);
    chk("midrst out stays 0", out_a, 0);
    run_a(2, 3, 0, 0, lat, res);
    chk("after rst latency", lat, 65);
    chk("after rst product", res, 6);

    // Instance B: 2-bit x 3 operands.
    run_b(3, 2, 3, lat, res);
    chk("B {3,2,3} latency", lat, exp_lat(1'b0, 0));
    chk("B {3,2,3} product", res, 18);
    run_b(0, 3, 3, lat, res);
    chk("B {0,3,3} latency", lat, exp_lat(1'b1, 0));
    chk("B {0,3,3} product", res, 0);
    run_b(3, 3, 3, lat, res);
    chk("B max latency", lat, exp_lat(1'b0, 0));
    chk("B max product", res, 27);
    for (int k = 0; k < 6; k++) begin
      x0 = int'($urandom_range(0, 3));
      x1 = int'($urandom_range(0, 3));
      x2 = int'($urandom_range(0, 3));
      run_b(x0, x1, x2, lat, res);
      chk($sformatf("rndB%0d latency", k), lat,
          exp_lat(x0 == 0 || x1 == 0 || x2 == 0, 0));
      chk($sformatf("rndB%0d product", k), res, x0 * x1 * x2);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ms_es_clkdiv_nmul.md
Name: ms_es_clkdiv_nmul

Overview:
Exact deterministic stochastic-computing multiplier for NUM_INPUTS unsigned binary operands, using clock-division unary streams.
- Operand i is encoded as the unary stream (cnt_i < x_i), where cnt_i is the i-th DATA_WIDTH-bit digit of one master counter. Digit 0 is least significant.
- All streams are ANDed, and a counter accumulates the ones. After 2^(DATA_WIDTH*NUM_INPUTS) cycles the accumulator holds the exact integer product.
- Parametrised N-input successor of the two-input naive by-2 multiplier. Adds stall-capable enable, start/done handshake and held result. Sits in the dsc arch_sweep cores behind the core wrapper.

Parameters:
- DATA_WIDTH, 5, bits per operand.
- NUM_INPUTS, 2, operand count; legal range 1..8.
- WXIP1, DATA_WIDTH*NUM_INPUTS+1, output width. Must be >= DATA_WIDTH*NUM_INPUTS; excess MSBs are zero.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  start request in IDLE; advance enable in RUN.
- bin_data_in  input  [DATA_WIDTH-1:0] x NUM_INPUTS  unpacked operand array; sampled only at start.
- bin_data_out  output  WXIP1  product, held until the next done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; master counter, accumulator and operand registers cleared.
  - bin_data_out=0, done=0.
  - Reset mid-RUN aborts the operation; no done is issued.
- Widths:
  - Master counter is DATA_WIDTH*NUM_INPUTS bits.
  - Accumulator is DATA_WIDTH*NUM_INPUTS bits; maximum value (2^DATA_WIDTH-1)^NUM_INPUTS, so it never overflows.
  - bin_data_out is the accumulator zero-extended to WXIP1.
- FSM IDLE:
  - done=0.
  - On en=1: latch bin_data_in into operand registers, clear counter and accumulator, go to RUN.
  - On en=0: stay in IDLE.
- FSM RUN:
  - en=1: stream bit = AND over i of (cnt_i < x_i); accumulator += stream bit; counter += 1.
  - en=0: full stall; counter, accumulator and state hold.
  - When an enabled cycle processes counter = all-ones, go to DONE with the final accumulator.
  - bin_data_in changes during RUN are ignored.
- FSM DONE (one cycle):
  - done=1; bin_data_out <= final accumulator, visible in the same cycle done is high.
  - Unconditionally return to IDLE; en in DONE is ignored.
- Latency, with en held high:
  - start edge -> 2^(DATA_WIDTH*NUM_INPUTS) RUN edges -> DONE.
  - done is high in the cycle following the (2^(DATA_WIDTH*NUM_INPUTS)+1)-th edge after the start edge.
  - Each en=0 cycle in RUN adds exactly one cycle.
- Back-to-back: en held high restarts in the IDLE cycle after DONE; minimum inter-done spacing is 2^(DATA_WIDTH*NUM_INPUTS)+2 cycles.
- Boundaries:
  - Operand 0 yields product 0.
  - All operands at maximum yield (2^DATA_WIDTH-1)^NUM_INPUTS.
  - NUM_INPUTS=1 degenerates to a unary counter: result = x_0.
  - Counter wrap from all-ones to 0 coincides with the RUN->DONE transition; the counter is never reused without a restart.
- bin_data_out changes only at DONE or reset.

Optional Feature:
- Macro: MS_ES_EARLY_TERM_EN.
- Defined:
  - At start in IDLE, if any bin_data_in[i]==0, go directly to DONE with accumulator=0.
  - done then occurs in the cycle after the start edge.
  - Otherwise behaviour is unchanged.
- Undefined: zero operands run the full 2^(DATA_WIDTH*NUM_INPUTS) cycles and still produce 0.
- Result values are identical in both builds; only latency differs.

Test Plan:
- DATA_WIDTH=3, NUM_INPUTS=2; inputs {5,7}; en held high -> done pulse exactly once, 65 edges after start; bin_data_out=35.
- Same configuration, inputs {7,7}, back-to-back with en held high -> two done pulses 66 cycles apart, both 49; bin_data_out holds 49 between pulses.
- DATA_WIDTH=2, NUM_INPUTS=3; inputs {3,2,3} -> bin_data_out=18 after 65 edges. Then {0,3,3} -> result 0.
  - Without MS_ES_EARLY_TERM_EN: done after 65 edges.
  - With MS_ES_EARLY_TERM_EN: done 1 cycle after the start edge.
- DATA_WIDTH=3, NUM_INPUTS=2; inputs {6,3}; en dropped for 10 cycles mid-RUN and bin_data_in changed to {1,1} meanwhile -> done delayed by exactly 10 cycles; bin_data_out=18.
- Reset mid-operation: run {4,4}, assert rst=0 at cycle 30 -> bin_data_out=0 and done=0 immediately, no done for the aborted run. Then start {2,3} -> done after 65 edges with 6.
